// File: rtl/lsu_mem_arbiter_if.sv
// Handshake bundle between the per-thread LSUs, the arbiter and the data-memory port.
// Latency: none (wires only).
// Backpressure: carried by the consumer/memory ready signals defined here.
// Ports: master = arbiter side (drives consumer readies/data, mem requests, busy);
//        slave  = environment side (LSUs and memory).
interface lsu_mem_arbiter_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8
);
  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]                 consumer_read_ready;
  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid;
  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0] consumer_write_address;
  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]                 consumer_write_ready;
  logic                                     mem_read_valid;
  logic [ADDR_WIDTH-1:0]                    mem_read_address;
  logic                                     mem_read_ready;
  logic [DATA_WIDTH-1:0]                    mem_read_data;
  logic                                     mem_write_valid;
  logic [ADDR_WIDTH-1:0]                    mem_write_address;
  logic [DATA_WIDTH-1:0]                    mem_write_data;
  logic                                     mem_write_ready;
  logic                                     busy;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready,
    output busy
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready,
    input  busy
  );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory read/write port among NUM_CONSUMERS LSUs.
// Latency: grant on first edge, completion on edge that samples mem ready, release when consumer valid drops.
// Backpressure: one transaction in flight; other requesters wait (level valid) until the current one is released.
// Ports: clk, rst_n (async active-low), bus (lsu_mem_arbiter_if.master: consumer and memory handshakes, busy).
module lsu_mem_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic clk,
  input  logic rst_n,
  lsu_mem_arbiter_if.master bus
);

  localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_READ    = 2'd1,
    ARB_WRITE   = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  arb_state_e                               state_q;
  logic [IW-1:0]                            rr_ptr_q;
  logic [IW-1:0]                            g_q;
  logic                                     is_read_q;
  logic [ADDR_WIDTH-1:0]                    mem_addr_q;
  logic [DATA_WIDTH-1:0]                    mem_wdata_q;
  logic                                     mem_rvld_q;
  logic                                     mem_wvld_q;
  logic [NUM_CONSUMERS-1:0]                 rd_rdy_q;
  logic [NUM_CONSUMERS-1:0]                 wr_rdy_q;
  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] rd_data_q;

  // Combinational winner search, consumed only in ARB_IDLE.
  logic          win_found_d;
  logic [IW-1:0] win_idx_d;
  logic          win_rd_d;
  logic          rel_vld_d;

  // Scan starting at rr_ptr_q; wider sum so the wrap works for non power-of-2 counts.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    win_found_d = 1'b0;
    win_idx_d   = '0;
    win_rd_d    = 1'b0;
    sum         = '0;
    cand        = '0;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (sum >= (IW+1)'(NUM_CONSUMERS)) begin
        sum = sum - (IW+1)'(NUM_CONSUMERS);
      end
      cand = sum[IW-1:0];
      if (!win_found_d && (bus.consumer_read_valid[cand] || bus.consumer_write_valid[cand])) begin
        win_found_d = 1'b1;
        win_idx_d   = cand;
        // Read has priority when a consumer raises both; the write waits for a later grant.
        win_rd_d    = bus.consumer_read_valid[cand];
      end
    end
  end

  // Release waits on the valid matching the kind of transaction just completed.
  assign rel_vld_d = is_read_q ? bus.consumer_read_valid[g_q] : bus.consumer_write_valid[g_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      g_q         <= '0;
      is_read_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rvld_q  <= 1'b0;
      mem_wvld_q  <= 1'b0;
      rd_rdy_q    <= '0;
      wr_rdy_q    <= '0;
      rd_data_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (win_found_d) begin
            g_q       <= win_idx_d;
            is_read_q <= win_rd_d;
            if (win_rd_d) begin
              mem_addr_q <= bus.consumer_read_address[win_idx_d];
              mem_rvld_q <= 1'b1;
              state_q    <= ARB_READ;
            end else begin
              mem_addr_q  <= bus.consumer_write_address[win_idx_d];
              mem_wdata_q <= bus.consumer_write_data[win_idx_d];
              mem_wvld_q  <= 1'b1;
              state_q     <= ARB_WRITE;
            end
          end
        end
        ARB_READ: begin
          if (bus.mem_read_ready) begin
            rd_data_q[g_q] <= bus.mem_read_data;
            rd_rdy_q[g_q]  <= 1'b1;
            mem_rvld_q     <= 1'b0;
            state_q        <= ARB_RELEASE;
          end
        end
        ARB_WRITE: begin
          if (bus.mem_write_ready) begin
            wr_rdy_q[g_q] <= 1'b1;
            mem_wvld_q    <= 1'b0;
            state_q       <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          if (!rel_vld_d) begin
            rd_rdy_q <= '0;
            wr_rdy_q <= '0;
            rr_ptr_q <= (g_q == IW'(NUM_CONSUMERS-1)) ? '0 : g_q + 1'b1;
            state_q  <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.consumer_read_ready  = rd_rdy_q;
  assign bus.consumer_read_data   = rd_data_q;
  assign bus.consumer_write_ready = wr_rdy_q;
  assign bus.mem_read_valid       = mem_rvld_q;
  assign bus.mem_read_address     = mem_addr_q;
  assign bus.mem_write_valid      = mem_wvld_q;
  assign bus.mem_write_address    = mem_addr_q;
  assign bus.mem_write_data       = mem_wdata_q;
  assign bus.busy                 = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter with a behavioural memory and auto-releasing LSUs.
// Latency: memory answers after a programmable stall count.
// Backpressure: consumers drop valid on seeing ready (auto mode) or under explicit control.
module tb_lsu_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;
  initial forever #5 clk = ~clk;

  lsu_mem_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  lsu_mem_arbiter #(.NUM_CONSUMERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] mem [256];
  int  stall;
  int  rd_wait, wr_wait;
  bit  auto_rel;
  bit  excl_bad, onehot_bad;
  int            log_id  [$];
  bit            log_rd  [$];
  logic [DW-1:0] log_dat [$];
  logic [N-1:0]  prev_rr, prev_wr;
  logic [AW-1:0] last_wr_addr;
  logic [DW-1:0] last_wr_data;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: sample after the edge, then play memory and consumer roles.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.mem_read_valid && bus.mem_write_valid) excl_bad = 1'b1;
    if ($countones({bus.consumer_read_ready, bus.consumer_write_ready}) > 1) onehot_bad = 1'b1;
    if (bus.mem_read_ready) begin
      bus.mem_read_ready = 1'b0;
      rd_wait = 0;
    end else if (bus.mem_read_valid) begin
      if (rd_wait >= stall) begin
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = mem[bus.mem_read_address];
      end else rd_wait++;
    end
    if (bus.mem_write_ready) begin
      bus.mem_write_ready = 1'b0;
      wr_wait = 0;
    end else if (bus.mem_write_valid) begin
      if (wr_wait >= stall) begin
        bus.mem_write_ready = 1'b1;
        mem[bus.mem_write_address] = bus.mem_write_data;
        last_wr_addr = bus.mem_write_address;
        last_wr_data = bus.mem_write_data;
      end else wr_wait++;
    end
    for (int i = 0; i < N; i++) begin
      if (bus.consumer_read_ready[i] && !prev_rr[i]) begin
        log_id.push_back(i); log_rd.push_back(1'b1); log_dat.push_back(bus.consumer_read_data[i]);
        if (auto_rel) bus.consumer_read_valid[i] = 1'b0;
      end
      if (bus.consumer_write_ready[i] && !prev_wr[i]) begin
        log_id.push_back(i); log_rd.push_back(1'b0); log_dat.push_back('0);
        if (auto_rel) bus.consumer_write_valid[i] = 1'b0;
      end
    end
    prev_rr = bus.consumer_read_ready;
    prev_wr = bus.consumer_write_ready;
  endtask

  task automatic wait_quiet(input string tag);
    for (int t = 0; t < 300 && (|bus.consumer_read_valid || |bus.consumer_write_valid || bus.busy); t++) tick();
    chk({tag, "_done"}, {30'd0, (|bus.consumer_read_valid || |bus.consumer_write_valid), bus.busy}, 32'd0);
  endtask

  task automatic clear_log();
    log_id.delete(); log_rd.delete(); log_dat.delete();
  endtask

  initial begin
    rst_n = 1'b1;
    bus.consumer_read_valid    = '0;
    bus.consumer_read_address  = '0;
    bus.consumer_write_valid   = '0;
    bus.consumer_write_address = '0;
    bus.consumer_write_data    = '0;
    bus.mem_read_ready  = 1'b0;
    bus.mem_read_data   = '0;
    bus.mem_write_ready = 1'b0;
    stall = 1; rd_wait = 0; wr_wait = 0; auto_rel = 1'b1;
    excl_bad = 1'b0; onehot_bad = 1'b0; prev_rr = '0; prev_wr = '0;
    last_wr_addr = '0; last_wr_data = '0;
    for (int a = 0; a < 256; a++) mem[a] = 8'(a + 8'h80);
    mem[8'h3C] = 8'hA5;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_mem_rvld", bus.mem_read_valid, 0);
    chk("rst_mem_wvld", bus.mem_write_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdy", {bus.consumer_read_ready, bus.consumer_write_ready}, 0);
    chk("rst_rdata", bus.consumer_read_data, 0);
    tick(); tick();
    rst_n = 1'b1;

    // Reset mid-read
    stall = 100;
    bus.consumer_read_address[2] = 8'h10;
    bus.consumer_read_valid[2]   = 1'b1;
    for (int t = 0; t < 10 && !bus.mem_read_valid; t++) tick();
    chk("midrd_vld_up", bus.mem_read_valid, 1);
    chk("midrd_addr", bus.mem_read_address, 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("midrd_vld_drop", bus.mem_read_valid, 0);
    chk("midrd_busy", bus.busy, 0);
    chk("midrd_rdy", {bus.consumer_read_ready, bus.consumer_write_ready}, 0);
    chk("midrd_rdata", bus.consumer_read_data, 0);
    bus.consumer_read_valid = '0;
    rd_wait = 0; stall = 1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrd_idle", bus.busy, 0);
    chk("midrd_rrptr", dut.rr_ptr_q, 0);

    // All four read at once, rr_ptr = 0
    clear_log();
    for (int i = 0; i < N; i++) bus.consumer_read_address[i] = 8'(i);
    bus.consumer_read_valid = 4'b1111;
    wait_quiet("rr4");
    chk("rr4_count", log_id.size(), 4);
    for (int k = 0; k < 4 && k < log_id.size(); k++) begin
      chk($sformatf("rr4_order%0d", k), log_id[k], k);
      chk($sformatf("rr4_data%0d", k), log_dat[k], 32'h80 + k);
    end

    // Request set {0,3}: 0 first, then 3
    clear_log();
    bus.consumer_read_valid = 4'b1001;
    wait_quiet("rr03");
    chk("rr03_count", log_id.size(), 2);
    if (log_id.size() == 2) begin
      chk("rr03_first", log_id[0], 0);
      chk("rr03_second", log_id[1], 3);
    end
    chk("rr03_rrptr", dut.rr_ptr_q, 0);

    // Single read, consumer holds valid manually
    auto_rel = 1'b0;
    bus.consumer_read_address[1] = 8'h3C;
    bus.consumer_read_valid[1]   = 1'b1;
    for (int t = 0; t < 20 && !bus.consumer_read_ready[1]; t++) tick();
    chk("single_rdy", bus.consumer_read_ready[1], 1);
    chk("single_data", bus.consumer_read_data[1], 32'hA5);
    chk("single_other_held", bus.consumer_read_data[0], 32'h80);
    tick();
    chk("single_rdy_hold", bus.consumer_read_ready[1], 1);
    bus.consumer_read_valid[1] = 1'b0;
    tick();
    chk("single_rdy_clr", bus.consumer_read_ready[1], 0);
    chk("single_busy_clr", bus.busy, 0);
    chk("single_data_held", bus.consumer_read_data[1], 32'hA5);
    auto_rel = 1'b1;

    // Write 0x55 to 0x20 from consumer 0, then consumer 1 reads it back
    clear_log();
    bus.consumer_write_address[0] = 8'h20;
    bus.consumer_write_data[0]    = 8'h55;
    bus.consumer_write_valid[0]   = 1'b1;
    wait_quiet("mix_wr");
    chk("mix_wr_addr", last_wr_addr, 32'h20);
    chk("mix_wr_data", last_wr_data, 32'h55);
    bus.consumer_read_address[1] = 8'h20;
    bus.consumer_read_valid[1]   = 1'b1;
    wait_quiet("mix_rd");
    chk("mix_rd_data", bus.consumer_read_data[1], 32'h55);
    if (log_id.size() == 2) chk("mix_first_is_wr", log_rd[0], 0);
    else chk("mix_count", log_id.size(), 2);

    // Consumer 3 raises read and write together
    clear_log();
    bus.consumer_read_address[3]  = 8'h03;
    bus.consumer_write_address[3] = 8'h40;
    bus.consumer_write_data[3]    = 8'h77;
    bus.consumer_read_valid[3]    = 1'b1;
    bus.consumer_write_valid[3]   = 1'b1;
    wait_quiet("both");
    chk("both_count", log_id.size(), 2);
    if (log_id.size() == 2) begin
      chk("both_first_rd", {log_id[0][7:0], 7'd0, log_rd[0]}, {8'd3, 8'd1});
      chk("both_rd_data", log_dat[0], 32'h83);
      chk("both_second_wr", {log_id[1][7:0], 7'd0, log_rd[1]}, {8'd3, 8'd0});
    end
    chk("both_mem", mem[8'h40], 32'h77);

    // Memory stall of 10 cycles with a competing request
    clear_log();
    stall = 10;
    bus.consumer_read_address[2] = 8'h10;
    bus.consumer_read_valid[2]   = 1'b1;
    for (int t = 0; t < 10 && !bus.mem_read_valid; t++) tick();
    chk("stall_vld_up", bus.mem_read_valid, 1);
    bus.consumer_read_address[0] = 8'h00;
    bus.consumer_read_valid[0]   = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      chk($sformatf("stall_addr%0d", t), bus.mem_read_address, 32'h10);
      chk($sformatf("stall_busy%0d", t), bus.busy, 1);
      chk($sformatf("stall_nogrant%0d", t), {bus.consumer_read_ready, bus.consumer_write_ready}, 0);
    end
    wait_quiet("stall");
    chk("stall_count", log_id.size(), 2);
    if (log_id.size() == 2) begin
      chk("stall_first", log_id[0], 2);
      chk("stall_first_data", log_dat[0], 32'h90);
      chk("stall_second", log_id[1], 0);
    end
    stall = 1;

    chk("mem_vld_exclusive", excl_bad, 0);
    chk("ready_onehot", onehot_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
